// File: rtl/pixel_mask_stage.sv
// pixel_mask_stage
//   Thresholds one colour channel of each RGB565 pixel and streams the
//   coordinates of in-mask pixels to the centroid block. A one-cycle
//   tabulate pulse follows the drain of the last pixel of each frame and
//   publishes that frame's in-mask pixel count.
//
// Ports
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   hcount_in, vcount_in      pixel column / row
//   pixel_in                  RGB565 pixel, R[15:11] G[10:5] B[4:0]
//   pixel_valid_in            qualifies coordinates and pixel
//   channel_sel_in            0=R 1=G 2=B 3=mask disabled
//   lo_in, hi_in              inclusive 6-bit threshold window
//   x_out, y_out, valid_out   in-mask pixel stream
//   mask_out, mask_valid_out  per-pixel mask bit for display overlay
//   tabulate_out              end-of-frame pulse
//   mask_count_out            in-mask count of last completed frame
//   error_out                 sticky truncated-frame flag
//
// state    | meaning
// ---------+----------------------------------------------------------
// WAIT_SOF | ignore pixels until the (0,0) pixel arrives
// ACTIVE   | accept every valid pixel until (H_ACTIVE-1, V_ACTIVE-1)
// FLUSH    | two cycles, pipeline drains, incoming pixels dropped
// TAB      | one cycle, count published on the following cycle

module pixel_mask_stage #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid_in,
    input  logic [1:0]  channel_sel_in,
    input  logic [5:0]  lo_in,
    input  logic [5:0]  hi_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        mask_out,
    output logic        mask_valid_out,
    output logic        tabulate_out,
    output logic [20:0] mask_count_out,
    output logic        error_out
);

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] ACTIVE   = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;
    localparam logic [1:0] TAB      = 2'd3;

    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [20:0] COUNT_MAX = '1;

    logic [1:0]  state;
    logic        flush_cnt;

    logic [1:0]  sh_chan;
    logic [5:0]  sh_lo;
    logic [5:0]  sh_hi;

    logic        s1_valid;
    logic        s1_sof;
    logic [15:0] s1_pixel;
    logic [10:0] s1_x;
    logic [9:0]  s1_y;

    logic        s2_sof;
    logic [20:0] frame_cnt;

    logic        is_sof;
    logic        is_eof;
    logic        accept;
    logic [5:0]  chan_val;
    logic        in_mask;

    always_comb begin
        is_sof = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        is_eof = pixel_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
        accept = ((state == ACTIVE) && pixel_valid_in) ||
                 ((state == WAIT_SOF) && is_sof);
    end

    // Stage-1 pixel is compared against thresholds that were captured
    // together with the SOF pixel, so the SOF pixel already sees them.
    always_comb begin
        chan_val = 6'd0;
        in_mask  = 1'b0;
        case (sh_chan)
            2'd0:    chan_val = {s1_pixel[15:11], 1'b0};
            2'd1:    chan_val = s1_pixel[10:5];
            2'd2:    chan_val = {s1_pixel[4:0], 1'b0};
            default: chan_val = 6'd0;
        endcase
        if (sh_chan != 2'd3) begin
            in_mask = (chan_val >= sh_lo) && (chan_val <= sh_hi);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= WAIT_SOF;
            flush_cnt      <= 1'b0;
            sh_chan        <= 2'd3;
            sh_lo          <= 6'd0;
            sh_hi          <= 6'd0;
            s1_valid       <= 1'b0;
            s1_sof         <= 1'b0;
            s1_pixel       <= 16'd0;
            s1_x           <= 11'd0;
            s1_y           <= 10'd0;
            s2_sof         <= 1'b0;
            frame_cnt      <= 21'd0;
            x_out          <= 11'd0;
            y_out          <= 10'd0;
            valid_out      <= 1'b0;
            mask_out       <= 1'b0;
            mask_valid_out <= 1'b0;
            tabulate_out   <= 1'b0;
            mask_count_out <= 21'd0;
            error_out      <= 1'b0;
        end else begin
            // stage 1
            s1_valid <= accept;
            s1_sof   <= accept && is_sof;
            s1_pixel <= pixel_in;
            s1_x     <= hcount_in;
            s1_y     <= vcount_in;

            if (accept && is_sof) begin
                sh_chan <= channel_sel_in;
                sh_lo   <= lo_in;
                sh_hi   <= hi_in;
            end

            // stage 2
            mask_valid_out <= s1_valid;
            mask_out       <= s1_valid && in_mask;
            valid_out      <= s1_valid && in_mask;
            x_out          <= s1_x;
            y_out          <= s1_y;
            s2_sof         <= s1_valid && s1_sof;

            // The clear rides down the pipeline with the SOF pixel so that
            // in-flight pixels of a truncated frame never leak into the new one.
            if (mask_valid_out && s2_sof) begin
                frame_cnt <= {20'd0, mask_out};
            end else if (valid_out && (frame_cnt != COUNT_MAX)) begin
                frame_cnt <= frame_cnt + 21'd1;
            end

            tabulate_out <= (state == TAB);
            if (state == TAB) begin
                mask_count_out <= frame_cnt;
            end

            case (state)
                WAIT_SOF: begin
                    if (is_sof) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (is_eof) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b0;
                    end else if (is_sof) begin
                        error_out <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        state <= TAB;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_SOF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_mask_stage.sv
module tb_pixel_mask_stage;

    localparam int H = 16;
    localparam int V = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        pixel_valid_in;
    logic [1:0]  channel_sel_in;
    logic [5:0]  lo_in;
    logic [5:0]  hi_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        mask_out;
    logic        mask_valid_out;
    logic        tabulate_out;
    logic [20:0] mask_count_out;
    logic        error_out;

    always #5 clk_in = ~clk_in;

    pixel_mask_stage #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
        .channel_sel_in(channel_sel_in), .lo_in(lo_in), .hi_in(hi_in),
        .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
        .mask_out(mask_out), .mask_valid_out(mask_valid_out),
        .tabulate_out(tabulate_out), .mask_count_out(mask_count_out),
        .error_out(error_out)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_tab = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct { logic [10:0] x; logic [9:0] y; int due; } px_exp_t;
    typedef struct { int due; logic [20:0] cnt; } tab_exp_t;
    typedef struct { logic [1:0] ch; logic [5:0] lo; logic [5:0] hi; logic [15:0] pix; logic exp_mask; } vec_t;

    px_exp_t  pq[$];
    tab_exp_t tq[$];
    px_exp_t  mon_p;
    tab_exp_t mon_t;

    // reference model state
    int         m_state = 0;   // 0 waiting for SOF, 1 in frame, 2 draining
    int         m_drop = 0;
    logic [1:0] m_ch = 2'd3;
    logic [5:0] m_lo = 6'd0;
    logic [5:0] m_hi = 6'd0;
    int         m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic ref_mask(input logic [1:0] ch, input logic [5:0] lo,
                                      input logic [5:0] hi, input logic [15:0] pix);
        logic [5:0] v;
        case (ch)
            2'd0:    v = {pix[15:11], 1'b0};
            2'd1:    v = pix[10:5];
            2'd2:    v = {pix[4:0], 1'b0};
            default: return 1'b0;
        endcase
        return (v >= lo) && (v <= hi);
    endfunction

    task automatic drive(input logic v, input int x, input int y, input logic [15:0] pix);
        bit acc, sof, eof;
        @(posedge clk_in); #1;
        pixel_valid_in = v;
        hcount_in = 11'(x);
        vcount_in = 10'(y);
        pixel_in = pix;
        sof = v && x == 0 && y == 0;
        eof = v && x == H - 1 && y == V - 1;
        acc = 0;
        if (m_state == 2) begin
            m_drop--;
            if (m_drop == 0) m_state = 0;
        end else if (m_state == 0) begin
            if (sof) begin acc = 1; m_state = 1; end
        end else begin
            acc = v;
            if (eof) begin m_state = 2; m_drop = 3; end
        end
        if (acc && sof) begin
            m_ch = channel_sel_in; m_lo = lo_in; m_hi = hi_in; m_cnt = 0;
        end
        if (acc) begin
            if (ref_mask(m_ch, m_lo, m_hi, pix)) begin
                pq.push_back('{11'(x), 10'(y), cyc + 2});
                if (m_cnt < 2097151) m_cnt++;
            end
            if (eof) tq.push_back('{cyc + 4, 21'(m_cnt)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0);
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_n_in = 0;
        pixel_valid_in = 0;
        @(posedge clk_in); #1;
        rst_n_in = 1;
        pq.delete(); tq.delete();
        m_state = 0; m_drop = 0; m_ch = 2'd3; m_lo = 0; m_hi = 0; m_cnt = 0;
        @(negedge clk_in);
        chk("reset_outputs_zero",
            {24'd0, valid_out, mask_out, mask_valid_out, tabulate_out, error_out,
             |x_out, |y_out, |mask_count_out}, 32'd0);
    endtask

    function automatic logic [15:0] pix_of(input int kind, input int x, input int y);
        case (kind)
            0:       return {5'd31, 6'd40, 5'd31};
            1:       return (x == 11 && y == 5) ? {5'd31, 6'd0, 5'd0} : 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic send_rows(input int y0, input int y1, input int kind, input bit gaps);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < H; x++) begin
                if (gaps && $urandom_range(0, 3) == 0) drive(0, x, y, pix_of(kind, x, y));
                drive(1, x, y, pix_of(kind, x, y));
            end
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        if (valid_out) begin
            n_valid++;
            if (pq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got x=%0d y=%0d expected no output (cycle %0d)", x_out, y_out, cyc);
            end else begin
                mon_p = pq.pop_front();
                chk("valid_x", 32'(x_out), 32'(mon_p.x));
                chk("valid_y", 32'(y_out), 32'(mon_p.y));
                chk("valid_latency", cyc, mon_p.due);
            end
        end else if (pq.size() != 0 && pq[0].due <= cyc) begin
            checks++;
            $display("FAIL missing_valid: got none expected x=%0d y=%0d at cycle %0d", pq[0].x, pq[0].y, pq[0].due);
            void'(pq.pop_front());
        end
        if (tabulate_out) begin
            n_tab++;
            if (tq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_tabulate: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_t = tq.pop_front();
                chk("tab_latency", cyc, mon_t.due);
                chk("tab_mask_count", 32'(mask_count_out), 32'(mon_t.cnt));
            end
        end else if (tq.size() != 0 && tq[0].due <= cyc) begin
            checks++;
            $display("FAIL missing_tabulate: got none expected pulse at cycle %0d", tq[0].due);
            void'(tq.pop_front());
        end
        if (valid_out && tabulate_out) begin
            checks++;
            $display("FAIL valid_tab_overlap: got both high expected exclusive (cycle %0d)", cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

    vec_t vecs[10];
    int n0, t0;

    initial begin
        vecs[0] = '{2'd0, 6'd60, 6'd63, {5'd31, 6'd0,  5'd0 }, 1'b1};
        vecs[1] = '{2'd0, 6'd60, 6'd63, {5'd29, 6'd63, 5'd31}, 1'b0};
        vecs[2] = '{2'd1, 6'd32, 6'd47, {5'd0,  6'd40, 5'd0 }, 1'b1};
        vecs[3] = '{2'd1, 6'd32, 6'd47, {5'd20, 6'd48, 5'd20}, 1'b0};
        vecs[4] = '{2'd2, 6'd32, 6'd32, {5'd0,  6'd0,  5'd16}, 1'b1};
        vecs[5] = '{2'd2, 6'd32, 6'd33, {5'd16, 6'd33, 5'd17}, 1'b0};
        vecs[6] = '{2'd1, 6'd63, 6'd63, {5'd0,  6'd63, 5'd0 }, 1'b1};
        vecs[7] = '{2'd1, 6'd0,  6'd0,  {5'd31, 6'd0,  5'd31}, 1'b1};
        vecs[8] = '{2'd1, 6'd20, 6'd5,  {5'd0,  6'd10, 5'd0 }, 1'b0};
        vecs[9] = '{2'd1, 6'd6,  6'd63, {5'd0,  6'd5,  5'd0 }, 1'b0};

        rst_n_in = 0; pixel_valid_in = 0; hcount_in = 0; vcount_in = 0; pixel_in = 0;
        channel_sel_in = 2'd1; lo_in = 6'd32; hi_in = 6'd47;
        do_reset();

        // pixels before any SOF are ignored
        n0 = n_valid; t0 = n_tab;
        drive(1, 3, 2, 16'h0500); drive(1, H - 1, V - 1, 16'h0500); drive(1, 5, 0, 16'h0500);
        idle(6);
        chk("pre_sof_valid", n_valid - n0, 0);
        chk("pre_sof_tab", n_tab - t0, 0);

        // full frame, G=40 in window
        n0 = n_valid; t0 = n_tab;
        send_rows(0, V - 1, 0, 0);
        idle(8);
        chk("full_valid_count", n_valid - n0, H * V);
        chk("full_tab_count", n_tab - t0, 1);
        chk("full_mask_count", 32'(mask_count_out), H * V);

        // per-pixel compare vectors
        for (int i = 0; i < 10; i++) begin
            do_reset();
            channel_sel_in = vecs[i].ch; lo_in = vecs[i].lo; hi_in = vecs[i].hi;
            drive(1, 0, 0, vecs[i].pix);
            idle(2);
            @(negedge clk_in);
            chk($sformatf("vec%0d_mask", i), 32'(mask_out), 32'(vecs[i].exp_mask));
            chk($sformatf("vec%0d_mask_valid", i), 32'(mask_valid_out), 32'd1);
        end
        do_reset();

        // single red pixel, with input gaps
        channel_sel_in = 2'd0; lo_in = 6'd60; hi_in = 6'd63;
        n0 = n_valid; t0 = n_tab;
        send_rows(0, V - 1, 1, 1);
        idle(8);
        chk("red_valid_count", n_valid - n0, 1);
        chk("red_tab_count", n_tab - t0, 1);
        chk("red_mask_count", 32'(mask_count_out), 1);

        // thresholds changed mid-frame take effect only at the next SOF
        channel_sel_in = 2'd1; lo_in = 6'd0; hi_in = 6'd63;
        n0 = n_valid;
        send_rows(0, 3, 2, 0);
        lo_in = 6'd63; hi_in = 6'd0;
        send_rows(4, V - 1, 2, 0);
        idle(8);
        chk("shadow_cur_valid", n_valid - n0, H * V);
        n0 = n_valid; t0 = n_tab;
        send_rows(0, V - 1, 2, 1);
        idle(8);
        chk("shadow_next_valid", n_valid - n0, 0);
        chk("shadow_next_tab", n_tab - t0, 1);
        chk("shadow_next_count", 32'(mask_count_out), 0);

        // truncated frame: (0,0) re-sent mid-frame
        lo_in = 6'd0; hi_in = 6'd63;
        t0 = n_tab;
        send_rows(0, 2, 2, 0);
        chk("trunc_err_before", 32'(error_out), 0);
        send_rows(0, V - 1, 2, 0);
        idle(8);
        chk("trunc_err_after", 32'(error_out), 1);
        chk("trunc_tab_count", n_tab - t0, 1);
        chk("trunc_mask_count", 32'(mask_count_out), H * V);

        // SOF right after EOF lands in FLUSH and the whole frame is skipped
        n0 = n_valid; t0 = n_tab;
        send_rows(0, V - 1, 2, 0);
        send_rows(0, V - 1, 0, 0);
        idle(8);
        chk("flush_sof_valid", n_valid - n0, H * V);
        chk("flush_sof_tab", n_tab - t0, 1);
        chk("flush_sof_count_hold", 32'(mask_count_out), H * V);

        // reset in mid-frame
        send_rows(0, 3, 2, 0);
        do_reset();
        n0 = n_valid; t0 = n_tab;
        send_rows(4, V - 1, 2, 0);
        idle(8);
        chk("midrst_valid", n_valid - n0, 0);
        chk("midrst_tab", n_tab - t0, 0);
        channel_sel_in = 2'd1; lo_in = 6'd32; hi_in = 6'd47;
        send_rows(0, V - 1, 0, 1);
        idle(8);
        chk("midrst_next_tab", n_tab - t0, 1);
        chk("midrst_next_count", 32'(mask_count_out), H * V);

        chk("pixel_queue_drained", pq.size(), 0);
        chk("tab_queue_drained", tq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pixel_mask_stage.md
Name: pixel_mask_stage

Overview:
- Upstream neighbour of the centroid block, between the camera pixel pipeline and centroid accumulation.
- Thresholds one selected colour channel of each RGB565 pixel and emits the coordinates of in-mask pixels as a valid-qualified stream.
- Issues a one-cycle tabulate pulse once the last pixel of a frame has drained from its pipeline.
- Reports the per-frame mask pixel count, and publishes a mask bit for display overlay.

Parameters:
- H_ACTIVE, 1024, active pixels per line; last column is H_ACTIVE-1.
- V_ACTIVE, 768, active lines per frame; last row is V_ACTIVE-1.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous reset, active-low.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- pixel_in  input  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- pixel_valid_in  input  1  qualifies hcount_in, vcount_in and pixel_in.
- channel_sel_in  input  2  channel select: 0=R, 1=G, 2=B, 3=mask disabled (never set).
- lo_in  input  6  inclusive lower threshold.
- hi_in  input  6  inclusive upper threshold.
- x_out  output  11  column of the in-mask pixel.
- y_out  output  10  row of the in-mask pixel.
- valid_out  output  1  in-mask pixel strobe.
- mask_out  output  1  mask bit, qualified by mask_valid_out.
- mask_valid_out  output  1  high for every accepted pixel, in mask or not.
- tabulate_out  output  1  one-cycle end-of-frame pulse.
- mask_count_out  output  21  in-mask pixel count of the last completed frame.
- error_out  output  1  sticky truncated-frame flag.

Behaviour:
- Reset is sampled on clk_in edge while rst_n_in=0.
- Reset values: every output 0, pipeline valids 0, FSM in WAIT_SOF, shadow thresholds 0 (channel 3).
- Reset mid-frame discards in-flight pixels; no valid_out or tabulate_out follows.
- Channel normalisation to 6 bits: R→{R,1'b0}, G→G, B→{B,1'b0}.
- In mask when lo ≤ value ≤ hi, unsigned. lo>hi gives an empty mask.
- Shadow registers: channel_sel_in, lo_in and hi_in are captured only on the cycle the SOF pixel (0,0) is accepted. They stay fixed for the whole frame.
- Pipeline, two stages:
  - Stage 1 registers the pixel and its coordinates.
  - Stage 2 registers the compare result.
  - valid_out, mask_out, mask_valid_out and coordinates appear 2 cycles after the accepting pixel_valid_in.
  - valid_out = mask_valid_out & mask_out.
- Accepted pixel: pixel_valid_in=1 while the FSM is in ACTIVE, or the SOF pixel while in WAIT_SOF.
- FSM states:
  - WAIT_SOF: ignore pixels until pixel_valid_in with (0,0). That pixel is accepted, thresholds are captured, frame count is cleared, and the FSM goes to ACTIVE.
  - ACTIVE: accept all valid pixels. The pixel at (H_ACTIVE-1, V_ACTIVE-1) is accepted and the FSM goes to FLUSH.
  - FLUSH: lasts exactly 2 cycles while the pipeline drains. Incoming pixels are dropped. Then go to TAB.
  - TAB: 1 cycle. Incoming pixels are dropped. Then go to WAIT_SOF.
  - tabulate_out and the mask_count_out update are registered off the TAB state and appear on the cycle after TAB.
- EOF timing: EOF pixel accepted at cycle t → its valid_out at t+2 → tabulate_out=1 at t+4 only.
- valid_out and tabulate_out are never high together.
- A SOF pixel arriving during FLUSH/TAB is dropped, so that frame is skipped.
- Frame counter: 21 bits, +1 per stage-2 in-mask pixel, saturating at 2^21-1.
  - Cleared at SOF acceptance; the SOF pixel's own contribution is added normally.
  - mask_count_out holds its value until the next tabulate.
- Truncated frame: a (0,0) pixel seen in ACTIVE other than as the first pixel sets error_out=1.
  - No tabulate is issued.
  - Thresholds are re-captured and the counter is cleared, starting a new frame.
  - error_out clears only on reset.
- Gaps in pixel_valid_in are allowed anywhere; the pipeline advances every cycle and its valids follow the input.

Test Plan:
- Reset, then a full 1024x768 frame with G=40, channel 1, lo=32, hi=47 on all pixels → valid_out for every pixel, 2-cycle latency; tabulate_out pulses exactly once, 2 cycles after the last valid_out; mask_count_out=786432.
- Single red pixel R=31 at (500,300), others 0, channel 0, lo=60, hi=63 → exactly one valid_out with x_out=500, y_out=300; mask_count_out=1.
- Thresholds changed from lo=0/hi=63 to lo=63/hi=0 mid-frame → current frame still all in mask; next frame has 0 valid_out; its mask_count_out=0, and tabulate_out still pulses.
- Pixels arriving before any SOF after reset → no valid_out, no tabulate_out until (0,0) is seen.
- (0,0) re-sent at row 100 → error_out=1, no tabulate_out; the following complete frame tabulates normally.
- rst_n_in=0 for 1 cycle in the middle of a frame → all outputs 0 the next cycle; no tabulate_out until a new full frame completes.
